mem_resp_slave: RTL
===================

Name: mem_resp_slave

Overview:
- Synthesizable word-addressed memory responder: the target end of the CHIP data-memory request interface (wen/addr/wdata/rdata).
- Adds a request/ready handshake with programmable access latency, so the core and cache are exercised against a non-zero-latency memory.
- Maps a window of DEPTH words starting at a runtime base offset; accesses outside the window are flagged and have no effect.
- Sits between CHIP (or its cache) and the backing store in the final-project system.

Parameters:
- DEPTH, 64, number of 32-bit words stored (power of two not required).
- LATENCY, 2, extra wait cycles per access; legal range 0..15.
- AW, 6, index width; must satisfy 2**AW >= DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- offset  in  32  byte base address of the window; stable while not IDLE.
- mem_cen  in  1  request valid; held high until mem_ready.
- mem_wen  in  1  1 = write, 0 = read; qualified by mem_cen.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_rdata  out  32  read data; valid when mem_ready=1, held until the next read completes.
- mem_ready  out  1  one-cycle completion pulse.
- mem_err  out  1  out-of-window flag; valid with mem_ready only.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, mem_ready=0, mem_err=0, mem_rdata=0, counter=0.
  - An in-flight access is abandoned, and a pending write is not committed.
  - Array contents are not cleared.
- States: IDLE, BUSY, RESP.
- IDLE:
  - When mem_cen=1 at an edge, the request is accepted (accept edge E0).
  - addr, wen and wdata are latched at E0.
  - Next state is BUSY; counter loaded with LATENCY.
- BUSY:
  - If counter==0, go to RESP; otherwise decrement.
  - Request inputs are ignored while in BUSY.
- RESP:
  - mem_ready=1 for exactly one cycle, then return to IDLE.
  - mem_ready rises after edge E0+LATENCY+1.
- Index and window check: idx = (latched_addr - offset) >> 2, computed modulo 2**32; the access is in-window iff idx < DEPTH.
- Write:
  - The array word is updated at the edge entering RESP.
  - mem_rdata is unchanged.
  - If out of window, the write is discarded and mem_err=1 in RESP.
- Read:
  - mem_rdata is registered at the edge entering RESP.
  - If out of window, mem_rdata=0 and mem_err=1.
- Back-to-back requests:
  - mem_cen is only sampled in IDLE.
  - If the requester keeps mem_cen high through RESP, a new request is accepted at the first edge in IDLE.
  - Minimum period is LATENCY+3 cycles.
- Address wrap: offset near 2**32 wraps naturally through the modulo subtraction. Addresses below offset give a large idx and are out-of-window.
- mem_wen or mem_addr changing while not in IDLE has no effect; the latched values rule.
- rst asserted in any state takes priority over all transitions.

Optional Feature:
- Macro MEMSLV_ERRCNT_EN.
- Defined:
  - Adds output err_cnt[7:0], reset to 0.
  - Increments on each RESP cycle with mem_err=1 and saturates at 8'hFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_resp_pkg holds:
  - state enum (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - constant WORD_BYTES=4;
  - LATENCY width constant LAT_W=4.
- One natural sub-module, mem_resp_array: DEPTH x 32 synchronous-write/registered-read storage with index, wen and re inputs.
- FSM, counter and window check stay in the top block.

Test Plan:
- Single write then read (DEPTH=64, LATENCY=2, offset=0x0001_0090):
  - Write 0xDEAD_BEEF to 0x0001_0094; mem_ready rises 3 cycles after accept.
  - A read of the same address returns 0xDEAD_BEEF with mem_err=0.
- Latency sweep: LATENCY=0 and 15 → mem_ready rises exactly 1 and 16 cycles after the accept edge, for exactly one cycle each.
- Out-of-window access (offset=0x0001_0090):
  - Read 0x0001_008C returns 0 with mem_err=1.
  - Write to offset+256 is discarded; a later read of index 0 is unchanged.
  - With MEMSLV_ERRCNT_EN defined, err_cnt=2.
- Back-to-back with mem_cen held high: 4 writes to consecutive words → accepts spaced LATENCY+3=5 cycles apart, and all 4 words read back correctly.
- Reset mid-operation:
  - Assert rst in BUSY of a write of 0x1234_5678 → mem_ready stays 0 and mem_rdata=0.
  - A later read returns the prior contents of that word.
- Address LSBs and wrap:
  - Write to offset+0x2 lands in index 0.
  - With offset=0xFFFF_FFF8, an access to 0x0000_0004 maps to index 3 and is in-window.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder slice: FSM state
// encoding, latched request struct and the byte-address to word-index helper.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int LAT_W      = 4;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Modulo-2**32 subtraction lets a base near the top of the space wrap cleanly.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        return (addr - base) >> $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// DEPTH x 32 storage: synchronous write, registered read. The hit input
// suppresses writes and forces read data to zero for out-of-window accesses.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] idx,
    input  logic          wen,
    input  logic          re,
    input  logic          hit,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wen && hit)
            mem[idx] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= hit ? mem[idx] : '0;
    end

endmodule

// File: rtl/mem_resp_slave.sv
// Word-addressed memory responder with request/ready handshake and
// programmable latency. Optional error counter under MEMSLV_ERRCNT_EN.
module mem_resp_slave
    import mem_resp_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2,
    parameter int AW      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] offset,
    input  logic        mem_cen,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err
`ifdef MEMSLV_ERRCNT_EN
   ,output logic [7:0]  err_cnt
`endif
);

    state_t           state_q, state_d;
    logic [LAT_W-1:0] cnt_q;
    mem_req_t         req_q;
    logic             err_q;
    logic             accept, busy_done;
    logic [31:0]      idx32;
    logic             hit;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        busy_done = 1'b0;
        case (state_q)
            IDLE: if (mem_cen) begin
                accept  = 1'b1;
                state_d = BUSY;
            end
            BUSY: if (cnt_q == '0) begin
                busy_done = 1'b1;
                state_d   = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (accept)
            cnt_q <= LAT_W'(LATENCY);
        else if (state_q == BUSY && cnt_q != '0)
            cnt_q <= cnt_q - LAT_W'(1);
    end

    // Request fields are frozen at accept; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst)
            req_q <= '0;
        else if (accept)
            req_q <= '{wen: mem_wen, addr: mem_addr, wdata: mem_wdata};
    end

    assign idx32 = word_index(req_q.addr, offset);
    assign hit   = idx32 < 32'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (busy_done)
            err_q <= ~hit;
    end

    // Array is written/read on the edge entering RESP; reset blocks a pending write.
    mem_resp_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .rst   (rst),
        .idx   (idx32[AW-1:0]),
        .wen   (busy_done &  req_q.wen & ~rst),
        .re    (busy_done & ~req_q.wen & ~rst),
        .hit   (hit),
        .wdata (req_q.wdata),
        .rdata (mem_rdata)
    );

    assign mem_ready = (state_q == RESP);
    assign mem_err   = mem_ready & err_q;

`ifdef MEMSLV_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if (mem_err && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule
